mdu_seq: RTL and testbench

Iterative multiply/divide sequencer for the RV32M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) that the decoder emits on the ALU-control bus.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one M-op at a time and runs a 32-step shift-add or restoring-division loop.
- Holds the pipeline via a stall output and returns the 32-bit result with a one-cycle valid pulse.

---
 rtl/mdu_seq_pkg.sv | 32 +++
 rtl/mdu_seq_core_step.sv | 35 +++
 rtl/mdu_seq.sv | 151 +++++++++++++++
 tb/tb_mdu_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: ALU op codes,
// FSM state encoding and op-class helpers.
package mdu_seq_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [4:0] ALU_MUL    = 5'h10;
  localparam logic [4:0] ALU_MULH   = 5'h11;
  localparam logic [4:0] ALU_MULHSU = 5'h12;
  localparam logic [4:0] ALU_MULHU  = 5'h13;
  localparam logic [4:0] ALU_DIV    = 5'h14;
  localparam logic [4:0] ALU_DIVU   = 5'h15;
  localparam logic [4:0] ALU_REM    = 5'h16;
  localparam logic [4:0] ALU_REMU   = 5'h17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  function automatic logic is_m_op(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/mdu_seq_core_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// hi/lo form the 64-bit product, or remainder/quotient-with-dividend.
module mdu_core_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            borrow;

  always_comb begin
    add_sum = lo_i[0] ? ({1'b0, hi_i} + {1'b0, opnd_i}) : {1'b0, hi_i};
    rem_sh  = {hi_i, lo_i[XLEN-1]};
    borrow  = rem_sh < {1'b0, opnd_i};
    // When there is no borrow the true difference is below the divisor, so
    // the truncated subtraction is exact.
    diff    = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = borrow ? rem_sh[XLEN-1:0] : diff;
      lo_o = {lo_i[XLEN-2:0], ~borrow};
    end else begin
      hi_o = add_sum[XLEN:1];
      lo_o = {add_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: accepts one M-op, runs XLEN
// iterations, applies sign correction and pulses valid with the result.
module mdu_seq import mdu_seq_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_start_i,
  input  logic [4:0]      ex_op_i,
  input  logic [XLEN-1:0] ex_op_a_i,
  input  logic [XLEN-1:0] ex_op_b_i,
  input  logic            flush_i,
  output logic            mdu_stall_o,
  output logic            mdu_busy_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
  logic            neg_q, neg_d;

  logic [XLEN-1:0]   step_hi, step_lo;
  logic              m_op, idle_or_done, accept, fast, op_div_q;
  logic              sa, sb, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, corr_res;
  logic [2*XLEN-1:0] prod;

  assign op_div_q = is_div_op(op_q);

  mdu_core_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_div_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Operand magnitudes, result sign and the divide special cases
  always_comb begin
    sa     = (ex_op_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM}) & ex_op_a_i[XLEN-1];
    sb     = (ex_op_i inside {ALU_MULH, ALU_DIV, ALU_REM}) & ex_op_b_i[XLEN-1];
    mag_a  = sa ? -ex_op_a_i : ex_op_a_i;
    mag_b  = sb ? -ex_op_b_i : ex_op_b_i;
    neg_in = (ex_op_i == ALU_REM) ? sa : (sa ^ sb);
    fast   = is_div_op(ex_op_i) &
             ((ex_op_b_i == '0) |
              ((ex_op_i inside {ALU_DIV, ALU_REM}) &
               (ex_op_a_i == INT_MIN) & (ex_op_b_i == '1)));
    if (ex_op_b_i == '0)
      fast_res = (ex_op_i inside {ALU_DIV, ALU_DIVU}) ? '1 : ex_op_a_i;
    else
      fast_res = (ex_op_i == ALU_DIV) ? INT_MIN : '0;
  end

  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_q)
      prod = -prod;
    unique case (op_q)
      ALU_MUL:           corr_res = prod[XLEN-1:0];
      ALU_DIV, ALU_DIVU: corr_res = neg_q ? -lo_q : lo_q;
      ALU_REM, ALU_REMU: corr_res = neg_q ? -hi_q : hi_q;
      default:           corr_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  assign m_op         = ex_start_i & is_m_op(ex_op_i);
  assign idle_or_done = (state_q == S_IDLE) | (state_q == S_DONE);
  assign accept       = m_op & idle_or_done & ~flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    res_d   = res_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1))
            state_d = S_CORR;
        end
        S_CORR: begin
          res_d   = corr_res;
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        op_d   = ex_op_i;
        neg_d  = neg_in;
        cnt_d  = '0;
        hi_d   = '0;
        lo_d   = is_div_op(ex_op_i) ? mag_a : mag_b;
        opnd_d = is_div_op(ex_op_i) ? mag_b : mag_a;
        if (fast) begin
          res_d   = fast_res;
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign mdu_stall_o  = (m_op & idle_or_done & ~fast) |
                        (state_q == S_CALC) | (state_q == S_CORR);
  assign mdu_busy_o   = (state_q != S_IDLE);
  assign mdu_valid_o  = (state_q == S_DONE) & ~flush_i;
  assign mdu_result_o = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, results, stall, flush, back-to-back, reset.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_start_i;
  logic [4:0]  ex_op_i;
  logic [31:0] ex_op_a_i, ex_op_b_i;
  logic        flush_i;
  logic        mdu_stall_o, mdu_busy_o, mdu_valid_o;
  logic [31:0] mdu_result_o;

  int total = 0;
  int bad   = 0;

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_start_i   (ex_start_i),
    .ex_op_i      (ex_op_i),
    .ex_op_a_i    (ex_op_a_i),
    .ex_op_b_i    (ex_op_b_i),
    .flush_i      (flush_i),
    .mdu_stall_o  (mdu_stall_o),
    .mdu_busy_o   (mdu_busy_o),
    .mdu_valid_o  (mdu_valid_o),
    .mdu_result_o (mdu_result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle T, then track the cycle of the valid pulse
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    int stall_cnt;
    @(negedge clk);
    ex_start_i = 1'b1; ex_op_i = op; ex_op_a_i = a; ex_op_b_i = b;
    #1;
    chk({tag, "_stall_T"}, 32'(mdu_stall_o), (exp_lat != 1) ? 32'd1 : 32'd0);
    @(posedge clk);
    #1 ex_start_i = 1'b0;
    lat = 0;
    stall_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mdu_valid_o) begin
        lat = i;
        break;
      end
      if (mdu_stall_o) stall_cnt++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, mdu_result_o, exp_res);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_lat - 1));
    chk({tag, "_stall_done"}, 32'(mdu_stall_o), 32'd0);
  endtask

  initial begin
    logic        seen;
    logic        got;
    logic [31:0] held;
    int          lat;

    rst_n = 1'b0; ex_start_i = 1'b0; ex_op_i = '0; ex_op_a_i = '0; ex_op_b_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(mdu_busy_o),  32'd0);
    chk("rst_valid",  32'(mdu_valid_o), 32'd0);
    chk("rst_result", mdu_result_o,     32'd0);
    chk("rst_stall",  32'(mdu_stall_o), 32'd0);
    rst_n = 1'b1;

    run_op("div",    ALU_DIV,    32'd7,        32'hFFFFFFFE, 34, 32'hFFFFFFFD);
    run_op("rem",    ALU_REM,    32'd7,        32'hFFFFFFFE, 34, 32'h00000001);
    run_op("divu0",  ALU_DIVU,   32'h1234,     32'h0,        1,  32'hFFFFFFFF);
    run_op("remu0",  ALU_REMU,   32'h1234,     32'h0,        1,  32'h00001234);
    run_op("divovf", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 1,  32'h80000000);
    run_op("removf", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 1,  32'h00000000);
    run_op("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000000);
    run_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE);
    run_op("mul",    ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'h00000001);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFF);

    // Flush in cycle T+10 of a DIVU
    held = 32'hFFFFFFFF;
    @(negedge clk);
    ex_start_i = 1'b1; ex_op_i = ALU_DIVU; ex_op_a_i = 32'd100; ex_op_b_i = 32'd7;
    @(posedge clk);
    #1 ex_start_i = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mdu_valid_o) seen = 1'b1;
    end
    chk("flush_busy_pre", 32'(mdu_busy_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy_post", 32'(mdu_busy_o), 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mdu_valid_o) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    chk("flush_res_held", mdu_result_o, held);

    run_op("mul3x5", ALU_MUL, 32'd3, 32'd5, 34, 32'd15);

    // Back-to-back: second MUL issued in the DONE cycle of the first
    @(negedge clk);
    ex_start_i = 1'b1; ex_op_i = ALU_MUL; ex_op_a_i = 32'd6; ex_op_b_i = 32'd7;
    @(posedge clk);
    #1 ex_start_i = 1'b0;
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mdu_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    chk("b2b_valid1", 32'(got), 32'd1);
    chk("b2b_res1", mdu_result_o, 32'd42);
    ex_start_i = 1'b1; ex_op_a_i = 32'd2; ex_op_b_i = 32'd9;
    @(posedge clk);
    #1 ex_start_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mdu_valid_o) begin
        lat = i;
        break;
      end
    end
    chk("b2b_lat2", 32'(lat), 32'd34);
    chk("b2b_res2", mdu_result_o, 32'd18);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    ex_start_i = 1'b1; ex_op_i = ALU_MUL; ex_op_a_i = 32'd11; ex_op_b_i = 32'd13;
    @(posedge clk);
    #1 ex_start_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(mdu_busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(mdu_busy_o),  32'd0);
    chk("arst_valid",  32'(mdu_valid_o), 32'd0);
    chk("arst_result", mdu_result_o,     32'd0);
    chk("arst_stall",  32'(mdu_stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst", ALU_DIVU, 32'd100, 32'd7, 34, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
